udma_ext_per_tx_serializer: RTL

Transmit datapath stage downstream of the external-peripheral uDMA register interface and TX channel. Accepts 32-bit words from the uDMA TX stream and serializes them into byte beats for the external peripheral. Byte count per word follows the programmed datasize. Optional inter-byte gap and enable come from the 32-bit setup register.

---
 rtl/udma_ext_per_pkg.sv | 31 +++
 rtl/udma_ext_per_word_buf.sv | 30 +++
 rtl/udma_ext_per_tx_serializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/udma_ext_per_pkg.sv
// Shared types and constants for the external-peripheral TX serializer.
package udma_ext_per_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned BEATS_W       = 3;
   localparam int unsigned SETUP_EN_BIT  = 0;
   localparam int unsigned SETUP_GAP_LSB = 8;
   localparam int unsigned SETUP_GAP_MSB = 15;

   localparam logic [1:0] DS_BYTE = 2'd0;
   localparam logic [1:0] DS_HALF = 2'd1;
   localparam logic [1:0] DS_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_e;

   // Byte beats carried by one word; the reserved encoding behaves as a full word.
   function automatic logic [BEATS_W-1:0] beats_of(input logic [1:0] ds);
      case (ds)
         DS_BYTE: beats_of = BEATS_W'(1);
         DS_HALF: beats_of = BEATS_W'(2);
         DS_WORD: beats_of = BEATS_W'(4);
         default: beats_of = BEATS_W'(4);
      endcase
   endfunction

endpackage

// File: rtl/udma_ext_per_word_buf.sv
// One-entry word/datasize holding register between the uDMA stream and the shifter.
module udma_ext_per_word_buf
   import udma_ext_per_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [1:0]        datasize_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic [WORD_W-1:0] word_o,
   output logic [1:0]        datasize_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_o     <= 1'b0;
         word_o     <= '0;
         datasize_o <= DS_BYTE;
      end else if (push_i) begin
         full_o     <= 1'b1;
         word_o     <= word_i;
         datasize_o <= datasize_i;
      end else if (pop_i) begin
         full_o     <= 1'b0;
      end
   end

endmodule

// File: rtl/udma_ext_per_tx_serializer.sv
// Serializes uDMA TX words into little-endian byte beats for the external peripheral.
// Optional inter-byte gap from setup_i[15:8] is built only with UDMA_EXT_PER_GAP_EN defined.
module udma_ext_per_tx_serializer
   import udma_ext_per_pkg::*;
#(
   parameter int unsigned TRANS_SIZE = 16
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [WORD_W-1:0]     setup_i,
   input  logic [WORD_W-1:0]     data_tx_i,
   input  logic [1:0]            data_tx_datasize_i,
   input  logic                  data_tx_valid_i,
   output logic                  data_tx_ready_o,
   output logic [BYTE_W-1:0]     ext_data_o,
   output logic                  ext_valid_o,
   output logic                  ext_last_o,
   input  logic                  ext_ready_i,
   output logic                  busy_o,
   input  logic                  cnt_clr_i,
   output logic [TRANS_SIZE-1:0] byte_cnt_o
);

   state_e                state_q, state_d;
   logic [WORD_W-1:0]     sh_word_q, sh_word_d;
   logic [BEATS_W-1:0]    sh_cnt_q, sh_cnt_d;
   logic [BEATS_W-1:0]    ld_beats;
   logic                  last_q, last_d;
   logic                  valid_q, valid_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic [TRANS_SIZE-1:0] cnt_q, cnt_d;

   logic                  tx_hs, ext_hs, gap_nz;
   logic                  load, load_buf;
   logic                  buf_push, buf_pop, buf_full, buf_full_d;
   logic [WORD_W-1:0]     buf_word;
   logic [1:0]            buf_ds;
   logic                  unused_setup;

`ifdef UDMA_EXT_PER_GAP_EN
   localparam int unsigned GAP_W = SETUP_GAP_MSB - SETUP_GAP_LSB + 1;
   logic [GAP_W-1:0] gap_q, gap_d;

   assign gap_nz       = |setup_i[SETUP_GAP_MSB:SETUP_GAP_LSB];
   assign unused_setup = ^{setup_i[WORD_W-1:SETUP_GAP_MSB+1],
                           setup_i[SETUP_GAP_LSB-1:SETUP_EN_BIT+1]};
`else
   assign gap_nz       = 1'b0;
   assign unused_setup = ^{setup_i[WORD_W-1:SETUP_GAP_MSB+1],
                           setup_i[SETUP_GAP_MSB:SETUP_EN_BIT+1]};
`endif

   assign tx_hs  = data_tx_valid_i & ready_q;
   assign ext_hs = valid_q & ext_ready_i;

   udma_ext_per_word_buf u_word_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (buf_push),
      .word_i     (data_tx_i),
      .datasize_i (data_tx_datasize_i),
      .pop_i      (buf_pop),
      .full_o     (buf_full),
      .word_o     (buf_word),
      .datasize_o (buf_ds)
   );

   // Next-state and shifter update; a word lands in the shifter whenever it is empty or emptying.
   always_comb begin
      state_d   = state_q;
      sh_word_d = sh_word_q;
      sh_cnt_d  = sh_cnt_q;
      last_d    = last_q;
      load      = 1'b0;
      load_buf  = 1'b0;
      ld_beats  = '0;
`ifdef UDMA_EXT_PER_GAP_EN
      gap_d     = gap_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (tx_hs) load = 1'b1;
         end
         ST_SHIFT: begin
            if (ext_hs) begin
               if (sh_cnt_q > BEATS_W'(1)) begin
                  sh_word_d = sh_word_q >> BYTE_W;
                  sh_cnt_d  = sh_cnt_q - BEATS_W'(1);
                  last_d    = (sh_cnt_q == BEATS_W'(2));
                  state_d   = gap_nz ? ST_GAP : ST_SHIFT;
               end else if (buf_full) begin
                  load     = 1'b1;
                  load_buf = 1'b1;
               end else if (tx_hs) begin
                  load     = 1'b1;
               end else begin
                  sh_cnt_d = '0;
                  state_d  = ST_IDLE;
               end
            end
         end
`ifdef UDMA_EXT_PER_GAP_EN
         ST_GAP: begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q <= GAP_W'(1)) state_d = ST_SHIFT;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         ld_beats  = beats_of(load_buf ? buf_ds : data_tx_datasize_i);
         sh_word_d = load_buf ? buf_word : data_tx_i;
         sh_cnt_d  = ld_beats;
         last_d    = (ld_beats == BEATS_W'(1));
         state_d   = (ext_hs && gap_nz) ? ST_GAP : ST_SHIFT;
      end
`ifdef UDMA_EXT_PER_GAP_EN
      if (state_q == ST_SHIFT && state_d == ST_GAP)
         gap_d = setup_i[SETUP_GAP_MSB:SETUP_GAP_LSB];
`endif
   end

   // Buffer control and registered-output next values.
   always_comb begin
      buf_pop    = load_buf;
      buf_push   = tx_hs & ~(load & ~load_buf);
      buf_full_d = (buf_full & ~buf_pop) | buf_push;
      valid_d    = (state_d == ST_SHIFT);
      busy_d     = (state_d != ST_IDLE) | buf_full_d;
      ready_d    = setup_i[SETUP_EN_BIT] & ~buf_full_d;
      if (cnt_clr_i)   cnt_d = '0;
      else if (ext_hs) cnt_d = cnt_q + TRANS_SIZE'(1);
      else             cnt_d = cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         sh_word_q <= '0;
         sh_cnt_q  <= '0;
         last_q    <= 1'b0;
         valid_q   <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
`ifdef UDMA_EXT_PER_GAP_EN
         gap_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sh_word_q <= sh_word_d;
         sh_cnt_q  <= sh_cnt_d;
         last_q    <= last_d;
         valid_q   <= valid_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
`ifdef UDMA_EXT_PER_GAP_EN
         gap_q     <= gap_d;
`endif
      end
   end

   assign data_tx_ready_o = ready_q;
   assign ext_data_o      = sh_word_q[BYTE_W-1:0];
   assign ext_valid_o     = valid_q;
   assign ext_last_o      = last_q;
   assign busy_o          = busy_q;
   assign byte_cnt_o      = cnt_q;

endmodule
